// File: rtl/exception_unit.sv
// Exception/interrupt sequencer for the LEGv8 single-cycle core.
// Ports: clk, reset (sync, high); ExtIRQ, NotAnInstr, ERet, ExcAck in;
// Exc, EStatus[3:0], ExtIAck, DblFault out (registered or state-decoded).
module exception_unit #(
  parameter logic [3:0] EST_IRQ   = 4'b0001,
  parameter logic [3:0] EST_BADOP = 4'b0010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ExtIRQ,
  input  logic       NotAnInstr,
  input  logic       ERet,
  input  logic       ExcAck,
  output logic       Exc,
  output logic [3:0] EStatus,
  output logic       ExtIAck,
  output logic       DblFault
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    EXC_REQ    = 2'd1,
    IN_HANDLER = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic armed;
  logic src_irq;

  logic take_bad;
  logic take_irq;
  logic acked;
  logic ret;
  logic dbl;

  always_comb begin
    state_nx = state;
    take_bad = 1'b0;
    take_irq = 1'b0;
    acked    = 1'b0;
    ret      = 1'b0;
    dbl      = 1'b0;
    unique case (state)
      RUN: begin
        // Bad opcode outranks the IRQ; the IRQ is level-held
        // so it is simply taken after the handler returns.
        if (NotAnInstr) begin
          take_bad = 1'b1;
          state_nx = EXC_REQ;
        end else if (ExtIRQ && armed) begin
          take_irq = 1'b1;
          state_nx = EXC_REQ;
        end
      end
      EXC_REQ: begin
        if (ExcAck) begin
          acked    = 1'b1;
          state_nx = IN_HANDLER;
        end
      end
      IN_HANDLER: begin
        if (ERet) begin
          ret      = 1'b1;
          state_nx = RUN;
        end else if (NotAnInstr) begin
          dbl = 1'b1;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  assign Exc = (state == EXC_REQ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      EStatus  <= 4'b0000;
      ExtIAck  <= 1'b0;
      DblFault <= 1'b0;
      armed    <= 1'b1;
      src_irq  <= 1'b0;
    end else begin
      state   <= state_nx;
      ExtIAck <= acked && src_irq;
      if (take_bad) begin
        EStatus <= EST_BADOP;
        src_irq <= 1'b0;
      end else if (take_irq) begin
        EStatus <= EST_IRQ;
        src_irq <= 1'b1;
      end else if (ret) begin
        EStatus <= 4'b0000;
      end
      // Seeing the line low always re-arms, even on the ack edge.
      if (!ExtIRQ) begin
        armed <= 1'b1;
      end else if (acked && src_irq) begin
        armed <= 1'b0;
      end
      if (dbl) begin
        DblFault <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Self-checking bench for exception_unit: directed table,
// hand-written corner sequences and randomized model comparison.
module tb_exception_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       ExtIRQ;
  logic       NotAnInstr;
  logic       ERet;
  logic       ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic       ExtIAck;
  logic       DblFault;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  exception_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ExtIRQ    (ExtIRQ),
    .NotAnInstr(NotAnInstr),
    .ERet      (ERet),
    .ExcAck    (ExcAck),
    .Exc       (Exc),
    .EStatus   (EStatus),
    .ExtIAck   (ExtIAck),
    .DblFault  (DblFault)
  );

  // Reference model: "requesting" and "handling" flags plus the
  // cause, an IRQ block flag and the sticky double-fault flag.
  bit         m_req;
  bit         m_hand;
  bit         m_from_irq;
  bit         m_blocked;
  bit         m_dbl;
  bit         m_ack;
  logic [3:0] m_cause;

  task automatic model_edge(input bit r, i, b, e, a);
    bit req, hand, from_irq, blocked, dbl, ackp;
    logic [3:0] cause;
    if (r) begin
      m_req = 0; m_hand = 0; m_from_irq = 0;
      m_blocked = 0; m_dbl = 0; m_ack = 0; m_cause = 4'd0;
      return;
    end
    req = m_req; hand = m_hand; from_irq = m_from_irq;
    blocked = m_blocked; dbl = m_dbl; cause = m_cause; ackp = 0;
    if (!m_req && !m_hand) begin
      if (b) begin
        req = 1; cause = 4'd2; from_irq = 0;
      end else if (i && !m_blocked) begin
        req = 1; cause = 4'd1; from_irq = 1;
      end
    end else if (m_req) begin
      if (a) begin
        req = 0; hand = 1; ackp = m_from_irq;
        if (m_from_irq) blocked = 1;
      end
    end else begin
      if (e) begin
        hand = 0; cause = 4'd0;
      end else if (b) begin
        dbl = 1;
      end
    end
    if (!i) blocked = 0;
    m_req = req; m_hand = hand; m_from_irq = from_irq;
    m_blocked = blocked; m_dbl = dbl; m_cause = cause; m_ack = ackp;
  endtask

  function automatic logic [7:0] dut_out();
    return {1'b0, Exc, EStatus, ExtIAck, DblFault};
  endfunction

  function automatic logic [7:0] mdl_out();
    return {1'b0, m_req, m_cause, m_ack, m_dbl};
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got {Exc,EStatus,IAck,Dbl}=%b expected %b",
                  nm, act[6:0], exp[6:0]);
  endtask

  task automatic step(input bit r, i, b, e, a);
    reset = r; ExtIRQ = i; NotAnInstr = b; ERet = e; ExcAck = a;
    @(posedge clk);
    model_edge(r, i, b, e, a);
    #1;
  endtask

  typedef struct {
    bit         r, i, b, e, a;
    bit         exc;
    logic [3:0] est;
    bit         iack, dbl;
  } vec_t;

  function automatic vec_t mk(bit r, i, b, e, a, exc,
                              logic [3:0] est, bit iack, dbl);
    vec_t v;
    v.r = r; v.i = i; v.b = b; v.e = e; v.a = a;
    v.exc = exc; v.est = est; v.iack = iack; v.dbl = dbl;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int pulses;
    int seen;
    bit irq_lvl;
    reset = 1; ExtIRQ = 0; NotAnInstr = 0; ERet = 0; ExcAck = 0;

    //               r i b e a  exc est  ia db
    tbl.push_back(mk(1,0,0,0,0, 0, 4'd0, 0,0)); // reset
    tbl.push_back(mk(0,1,0,0,0, 1, 4'd1, 0,0)); // irq taken
    tbl.push_back(mk(0,1,0,0,0, 1, 4'd1, 0,0)); // wait ack
    tbl.push_back(mk(0,1,0,0,1, 0, 4'd1, 1,0)); // ack -> iack
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd1, 0,0)); // iack one cycle
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd1, 0,0));
    tbl.push_back(mk(0,0,0,1,0, 0, 4'd0, 0,0)); // eret
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd0, 0,0));
    tbl.push_back(mk(0,1,1,0,0, 1, 4'd2, 0,0)); // badop wins
    tbl.push_back(mk(0,1,0,0,1, 0, 4'd2, 0,0)); // no iack
    tbl.push_back(mk(0,1,0,1,0, 0, 4'd0, 0,0)); // eret
    tbl.push_back(mk(0,1,0,0,0, 1, 4'd1, 0,0)); // pending irq
    tbl.push_back(mk(0,1,0,0,1, 0, 4'd1, 1,0));
    tbl.push_back(mk(0,1,0,0,0, 0, 4'd1, 0,0)); // masked
    tbl.push_back(mk(0,1,1,1,0, 0, 4'd0, 0,0)); // eret beats bad
    tbl.push_back(mk(0,1,0,0,0, 0, 4'd0, 0,0)); // disarmed
    tbl.push_back(mk(0,1,0,0,0, 0, 4'd0, 0,0));
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd0, 0,0)); // re-arm
    tbl.push_back(mk(0,1,0,0,0, 1, 4'd1, 0,0)); // second exc
    tbl.push_back(mk(0,0,0,0,1, 0, 4'd1, 1,0)); // dropped irq
    tbl.push_back(mk(0,0,1,0,0, 0, 4'd1, 0,1)); // double fault
    tbl.push_back(mk(0,0,0,1,0, 0, 4'd0, 0,1)); // sticky
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd0, 0,1));
    tbl.push_back(mk(0,1,0,0,1, 1, 4'd1, 0,1)); // ack early
    tbl.push_back(mk(0,1,0,0,1, 0, 4'd1, 1,1)); // 1 cycle Exc
    tbl.push_back(mk(0,0,0,1,0, 0, 4'd0, 0,1)); // eret, re-arm
    tbl.push_back(mk(0,1,0,0,0, 1, 4'd1, 0,1)); // 2 cyc later
    tbl.push_back(mk(1,1,0,0,0, 0, 4'd0, 0,0)); // reset mid-req
    tbl.push_back(mk(0,0,0,0,0, 0, 4'd0, 0,0));
    tbl.push_back(mk(0,0,0,1,0, 0, 4'd0, 0,0)); // eret ignored

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].i, tbl[k].b, tbl[k].e, tbl[k].a);
      chk($sformatf("vec%0d", k), dut_out(),
          {1'b0, tbl[k].exc, tbl[k].est, tbl[k].iack, tbl[k].dbl});
    end

    // Long ack wait with the IRQ dropped mid-request.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 0, 0, 0);
      chk("hold_req", {3'b0, Exc, EStatus}, {3'b0, 1'b1, 4'd1});
    end
    step(0, 0, 0, 0, 1);
    pulses = (ExtIAck === 1'b1) ? 1 : 0;
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0, 0, 0);
      if (ExtIAck === 1'b1) pulses++;
    end
    chk("iack_count", 8'(pulses), 8'd1);
    chk("est_kept", {4'b0, EStatus}, 8'd1);

    // Bounded wait: ERet then armed IRQ, Exc within budget.
    step(0, 1, 0, 1, 0);
    seen = 0;
    for (int c = 1; c <= 6 && seen == 0; c++) begin
      step(0, 1, 0, 0, 0);
      if (Exc === 1'b1) seen = c;
    end
    if (seen == 0) begin
      checks++;
      $display("FAIL exc_timeout: Exc never rose within 6 cycles");
    end else begin
      chk("exc_delay", 8'(seen), 8'd1);
    end

    // Randomized run against the model.
    step(1, 0, 0, 0, 0);
    irq_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) irq_lvl = ~irq_lvl;
      step($urandom_range(96) == 0, irq_lvl,
           $urandom_range(7) == 0, $urandom_range(4) == 0,
           $urandom_range(2) == 0);
      chk($sformatf("rand%0d", n), dut_out(), mdl_out());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
